// File: rtl/gpio_wb_arb2.sv
// Two-master Wishbone arbiter in front of the GPIO slave: whole-cycle grants,
// round-robin on contention, and a per-beat watchdog that answers a silent slave with err.
module gpio_wb_arb2 #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2, ERR = 2'd3} state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            errp_q, errp_d;
  logic            own_cyc, own_stb, wd_hit;

  // last always names the current owner while granted or in ERR
  assign own_cyc = last_q ? m1_cyc_i : m0_cyc_i;
  assign own_stb = last_q ? m1_stb_i : m0_stb_i;
  assign wd_hit  = (TIMEOUT != 0) && (cnt_q == TO_W'(TIMEOUT));

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      errp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      errp_q  <= errp_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    errp_d   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_dat_o = '0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
          state_d = GNT0;
          last_d  = 1'b0;
        end else if (m1_cyc_i) begin
          state_d = GNT1;
          last_d  = 1'b1;
        end
      end
      GNT0, GNT1: begin
        if (state_q == GNT1) begin
          s_cyc_o  = m1_cyc_i;
          s_stb_o  = m1_stb_i;
          s_we_o   = m1_we_i;
          s_sel_o  = m1_sel_i;
          s_adr_o  = m1_adr_i;
          s_dat_o  = m1_dat_i;
          m1_ack_o = s_ack_i;
          m1_dat_o = s_dat_i;
        end else begin
          s_cyc_o  = m0_cyc_i;
          s_stb_o  = m0_stb_i;
          s_we_o   = m0_we_i;
          s_sel_o  = m0_sel_i;
          s_adr_o  = m0_adr_i;
          s_dat_o  = m0_dat_i;
          m0_ack_o = s_ack_i;
          m0_dat_o = s_dat_i;
        end
        // an ack landing on the limit cycle wins over the watchdog
        if (!own_cyc) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (s_ack_i || !own_stb) begin
          cnt_d = '0;
        end else if (wd_hit) begin
          state_d = ERR;
          errp_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ERR: begin
        cnt_d    = '0;
        m0_err_o = errp_q & ~last_q;
        m1_err_o = errp_q & last_q;
        if (!own_cyc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/gpio_wb_arb2.md
# gpio_wb_arb2

Two-master Wishbone arbiter that shares the single GPIO Wishbone slave port (`gpio_wb`) between the management core and a second bus master, such as a debug or housekeeping engine. It grants one whole bus cycle at a time, using round-robin on contention. The grant is held until the owner drops `cyc`. A per-transfer watchdog terminates any transfer the slave never acknowledges, returning an error to the owning master.

## Interface
- `TIMEOUT`, default 255: slave-wait limit in cycles (1..2^TO_W-1); 0 disables the watchdog.
- `TO_W`, default 8: watchdog counter width.
- `wb_clk_i`  in  1  bus clock; all state on rising edge.
- `wb_rst_ni`  in  1  reset; asynchronous assert, active-low.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i`  in  1 each  master 0 cycle, strobe, write-enable.
- `m0_sel_i`  in  4  master 0 byte selects.
- `m0_adr_i`, `m0_dat_i`  in  32 each  master 0 address, write data.
- `m0_ack_o`, `m0_err_o`  out  1 each  master 0 acknowledge, error.
- `m0_dat_o`  out  32  master 0 read data.
- `m1_*`: same set as `m0_*`, for master 1.
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1 each  to slave.
- `s_sel_o`  out  4  to slave.
- `s_adr_o`, `s_dat_o`  out  32 each  to slave.
- `s_ack_i`  in  1  slave acknowledge.
- `s_dat_i`  in  32  slave read data.

## Operation
- **State machine** (registered): IDLE, GNT0, GNT1, ERR. A `last` register holds the most recently granted master; it resets to 1 so that master 0 wins the first contention.
- **IDLE**:
  - If only one `mX_cyc_i` is high, go to GNTX.
  - If both are high, grant the master that is not `last`.
  - Update `last` on every grant.
  - All `s_*` outputs are 0.
- **GNTX**:
  - `s_cyc_o`, `s_stb_o`, `s_we_o`, `s_sel_o`, `s_adr_o`, `s_dat_o` are combinational copies of master X inputs.
  - `mX_ack_o = s_ack_i`, `mX_dat_o = s_dat_i`.
  - The other master sees ack=0, err=0, dat=0. Its requests wait; they are not dropped.
- **Leaving GNTX**: on the edge where `mX_cyc_i` = 0, go to IDLE. There is no back-to-back regrant in the same edge, so there is always one idle cycle between owners.
- **Watchdog**:
  - A counter clears on entering GNTX, on every `s_ack_i`=1 cycle, and on every cycle with `s_stb_o`=0.
  - Otherwise it increments.
  - When the counter equals `TIMEOUT` (and TIMEOUT != 0), go to ERR.
- **ERR**:
  - All `s_*` outputs are 0, which aborts the slave cycle.
  - `mX_err_o` = 1 for exactly the first ERR cycle; `mX_ack_o` = 0.
  - Stay in ERR until `mX_cyc_i` = 0, then go to IDLE.
- **Simultaneous events**:
  - `s_ack_i` in the same cycle the counter reaches TIMEOUT: ack wins, the counter clears, and no error is raised.
  - Owner drops `cyc` while the other master requests: IDLE one cycle, then grant the other master.
- `s_dat_i` and `s_ack_i` are never registered. `mX_dat_o` reflects `s_dat_i` only while X owns the bus.

## Timing
- **Reset values**: state IDLE, `last`=1, counter 0. All outputs 0: `s_*`, `m*_ack_o`, `m*_err_o`, `m*_dat_o`.
- **Reset mid-transfer**: outputs go to 0 asynchronously, and the slave cycle is abandoned.
- **Grant latency**: `cyc`/`stb` seen high at edge N drives `s_cyc_o` during cycle N+1. Thereafter, ack passes to the master combinationally (0 cycles).
- **Single-cycle ack slave**: master-observed latency is 1 (grant) + slave latency.
- **Hand-over**: owner `cyc` low at edge N gives IDLE in cycle N+1. The next grant is visible in cycle N+2.
- **Timeout**: with `stb` held and no ack, ERR is entered TIMEOUT+1 cycles after the grant. `err` is high for one cycle.
- **Throughput**: one master cycle per grant. Several stb/ack beats within one `cyc` are allowed; the counter restarts per beat.

## Test plan
- **Reset**: assert `wb_rst_ni`=0 mid-GNT0 with `s_cyc_o`=1 → all outputs 0 immediately. After release, state is IDLE.
- **Single master write then read**:
  - m0 writes 32'h1 to GPIO_DATA with `gpio_in_pad`=1 → `m0_ack_o` pulses, `s_cyc_o` high one cycle after `cyc`.
  - m0 reads GPIO_DATA → `m0_dat_o` = 32'h3. m1 outputs stay 0 throughout.
- **Contention after reset**: m0 and m1 assert `cyc` in the same cycle → m0 granted first. m1 is granted two cycles after m0 drops `cyc`. m1 reads GPIO_PU = 32'h1 after m0 wrote 1.
- **Round-robin fairness**: both masters keep requesting, 8 transfers each → grants alternate m0,m1,m0,... and no master gets two consecutive grants.
- **Watchdog**:
  - TIMEOUT=4, slave ack forced 0 → `m1_err_o` = 1 for one cycle, 5 cycles after the grant. `s_cyc_o` drops in the same cycle. `m1_ack_o` is never asserted.
  - TIMEOUT=0 → no error after 1000 cycles.
- **Ack at the limit**: TIMEOUT=4, slave acks exactly on the 4th wait cycle → ack delivered, `err` stays 0, state remains GNTX until `cyc` drops.
